hr_window_ctrl: RTL and testbench

Measurement-window sequencer for the heart-rate path of the health monitor. It opens a fixed sampling window on a tick-based timebase and counts beat pulses from the pulse detector inside the window. At window end it publishes a scaled beats-per-minute result. In parallel it runs an inter-beat gap timer that raises a sticky `time_late` alarm when no beat arrives within the timeout, and it supports single-shot and continuous measurement modes.

---
 rtl/hr_window_ctrl.sv | 152 +++++++++++++++
 tb/tb_hr_window_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hr_window_ctrl.sv
// Heart-rate measurement window sequencer: counts beats over a tick-based window,
// publishes a saturated BPM figure and raises a sticky alarm on missing beats.
module hr_window_ctrl #(
    parameter int WINDOW_TICKS  = 10000,
    parameter int TIMEOUT_TICKS = 3000,
    parameter int BPM_MULT      = 6,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic             beat,
    input  logic             clear_late,
    output logic             busy,
    output logic             bpm_valid,
    output logic [CNT_W-1:0] bpm,
    output logic             time_late
);

    localparam int WIN_W  = (WINDOW_TICKS  > 1) ? $clog2(WINDOW_TICKS)  : 1;
    localparam int GAP_W  = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam int PROD_W = CNT_W + 4;

    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_TICKS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [PROD_W-1:0] MULT_C   = PROD_W'(BPM_MULT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_REPORT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic                r_busy;
    logic                r_bpm_valid;
    logic [CNT_W-1:0]    r_bpm;
    logic                r_time_late;

    logic                w_meas;
    logic                w_load;
    logic                w_win_end;
    logic                w_timeout;
    logic                w_beat_inc;
    logic [CNT_W-1:0]    w_beat_total;
    logic [PROD_W-1:0]   w_prod;

    function automatic logic [CNT_W-1:0] sat_bpm(input logic [PROD_W-1:0] prod);
        if (prod > {4'b0000, CNT_MAX})
            return CNT_MAX;
        return prod[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // REPORT lasts one cycle and ignores tick, so continuous mode drops one tick per window.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_win_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_MEASURE;
                    w_load      = 1'b1;
                end
            end
            S_MEASURE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (tick && (r_win_cnt == WIN_LAST)) begin
                    w_state_nxt = S_REPORT;
                    w_win_end   = 1'b1;
                end
            end
            S_REPORT: begin
                if (cont) begin
                    w_state_nxt = S_MEASURE;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_meas       = (r_state == S_MEASURE);
    assign w_timeout    = w_meas && tick && !beat && (r_gap_cnt == GAP_LAST);
    assign w_beat_inc   = w_meas && beat && (r_beat_cnt != CNT_MAX);
    // A beat on the closing tick is folded into the published result.
    assign w_beat_total = r_beat_cnt + CNT_W'(w_beat_inc);
    assign w_prod       = PROD_W'(w_beat_total) * MULT_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_beat_cnt <= '0;
        end else if (w_load) begin
            r_win_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_beat_cnt <= '0;
        end else if (w_meas) begin
            if (tick && (r_win_cnt != WIN_LAST))
                r_win_cnt <= r_win_cnt + WIN_W'(1);
            if (beat || w_timeout)
                r_gap_cnt <= '0;
            else if (tick)
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            if (w_beat_inc)
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_bpm_valid <= 1'b0;
            r_bpm       <= '0;
            r_time_late <= 1'b0;
        end else begin
            r_busy      <= (w_state_nxt != S_IDLE);
            r_bpm_valid <= w_win_end;
            if (w_win_end)
                r_bpm <= sat_bpm(w_prod);
            if (w_timeout)
                r_time_late <= 1'b1;
            else if (clear_late || (w_load && (r_state == S_IDLE)))
                r_time_late <= 1'b0;
        end
    end

    assign busy      = r_busy;
    assign bpm_valid = r_bpm_valid;
    assign bpm       = r_bpm;
    assign time_late = r_time_late;

endmodule

// File: tb/tb_hr_window_ctrl.sv
// Self-checking bench for hr_window_ctrl: vector table, directed corner sequences,
// a narrow-width saturation instance and randomized traffic against a reference model.
module tb_hr_window_ctrl;

    localparam int W    = 10;
    localparam int TO   = 4;
    localparam int MULT = 6;
    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, start = 1'b0, stop = 1'b0, cont = 1'b0, beat = 1'b0, clear_late = 1'b0;
    logic       busy, bpm_valid, time_late;
    logic [7:0] bpm;

    logic       s_start = 1'b0, s_beat = 1'b0;
    logic       s_busy, s_valid, s_late;
    logic [5:0] s_bpm;

    int n_checks = 0;
    int n_errors = 0;

    hr_window_ctrl #(.WINDOW_TICKS(W), .TIMEOUT_TICKS(TO), .BPM_MULT(MULT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop), .cont(cont),
        .beat(beat), .clear_late(clear_late), .busy(busy), .bpm_valid(bpm_valid),
        .bpm(bpm), .time_late(time_late)
    );

    hr_window_ctrl #(.WINDOW_TICKS(80), .TIMEOUT_TICKS(TO), .BPM_MULT(MULT), .CNT_W(6)) dut_sat (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(s_start), .stop(1'b0), .cont(1'b0),
        .beat(s_beat), .clear_late(1'b0), .busy(s_busy), .bpm_valid(s_valid),
        .bpm(s_bpm), .time_late(s_late)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: window bookkeeping in plain integers.
    int m_phase, m_ticks, m_beats, m_gap, m_late, m_bpm, m_valid, m_busy;

    task automatic model_reset();
        m_phase = 0; m_ticks = 0; m_beats = 0; m_gap = 0;
        m_late = 0; m_bpm = 0; m_valid = 0; m_busy = 0;
    endtask

    task automatic model_step(input int t, input int st, input int sp, input int ct,
                              input int bt, input int cl);
        int fire;
        int nb;
        fire = 0;
        m_valid = 0;
        if (m_phase == 0) begin
            if (st != 0) begin
                m_phase = 1; m_ticks = 0; m_beats = 0; m_gap = 0; m_late = 0;
            end
        end else if (m_phase == 1) begin
            nb = m_beats + bt;
            if (nb > MAXV) nb = MAXV;
            if (bt != 0) m_gap = 0;
            else if (t != 0) begin
                m_gap = m_gap + 1;
                if (m_gap == TO) begin
                    m_gap = 0;
                    fire = 1;
                end
            end
            if (sp != 0) m_phase = 0;
            else if (t != 0 && m_ticks == W - 1) begin
                m_valid = 1;
                m_bpm = (nb * MULT > MAXV) ? MAXV : nb * MULT;
                m_phase = 2;
            end else if (t != 0) m_ticks = m_ticks + 1;
            m_beats = nb;
        end else begin
            if (ct != 0) begin
                m_phase = 1; m_ticks = 0; m_beats = 0; m_gap = 0;
            end else m_phase = 0;
        end
        if (fire != 0) m_late = 1;
        else if (cl != 0) m_late = 0;
        m_busy = (m_phase != 0) ? 1 : 0;
    endtask

    typedef struct {
        logic       tick, start, stop, cont, beat, clr;
        logic       busy, valid;
        logic [7:0] bpm;
        logic       late;
    } vec_t;

    vec_t vecs[13];

    task automatic window_with_end_beat();
        start = 1'b1; step(); start = 1'b0;
        repeat (9) step();
        beat = 1'b1; step(); beat = 1'b0;
        check("endbeat_valid", int'(bpm_valid), 1);
        check("endbeat_bpm", int'(bpm), 6);
        step();
    endtask

    task automatic sat_run(input int nbeats, input int exp_bpm);
        s_start = 1'b1; step(); s_start = 1'b0;
        check("sat_late_cleared", int'(s_late), 0);
        for (int k = 0; k < 100; k++) begin
            s_beat = (k < nbeats);
            step();
            if (s_valid) break;
        end
        s_beat = 1'b0;
        check("sat_valid", int'(s_valid), 1);
        check("sat_bpm", int'(s_bpm), exp_bpm);
        step();
        check("sat_idle", int'(s_busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 13; i++) begin
            vecs[i] = '{tick: 1'b1, start: 1'b0, stop: 1'b0, cont: 1'b0, beat: 1'b0, clr: 1'b0,
                        busy: 1'b1, valid: 1'b0, bpm: 8'd0, late: 1'b0};
            if (i >= 1 && i <= 10) vecs[i].beat = (i % 2 == 1);
            if (i >= 11) begin
                vecs[i].busy = 1'b0;
                vecs[i].bpm  = 8'd30;
            end
        end
        vecs[0].start  = 1'b1;
        vecs[10].valid = 1'b1;
        vecs[10].bpm   = 8'd30;

        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(bpm_valid), 0);
        check("rst_bpm", int'(bpm), 0);
        check("rst_late", int'(time_late), 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Single-shot window from the vector table.
        foreach (vecs[i]) begin
            tick = vecs[i].tick; start = vecs[i].start; stop = vecs[i].stop;
            cont = vecs[i].cont; beat = vecs[i].beat; clear_late = vecs[i].clr;
            step();
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
            check($sformatf("vec%0d_valid", i), int'(bpm_valid), int'(vecs[i].valid));
            check($sformatf("vec%0d_bpm", i), int'(bpm), int'(vecs[i].bpm));
            check($sformatf("vec%0d_late", i), int'(time_late), int'(vecs[i].late));
        end
        start = 1'b0; beat = 1'b0; tick = 1'b1;

        // Gap alarm, report with alarm set, clear, and set-beats-clear.
        start = 1'b1; step(); start = 1'b0;
        repeat (3) step();
        check("gap_before", int'(time_late), 0);
        step();
        check("gap_set", int'(time_late), 1);
        repeat (6) step();
        check("gap_rep_valid", int'(bpm_valid), 1);
        check("gap_rep_bpm", int'(bpm), 0);
        check("gap_rep_late", int'(time_late), 1);
        step();
        check("gap_idle_busy", int'(busy), 0);
        check("gap_idle_late", int'(time_late), 1);
        clear_late = 1'b1; step(); clear_late = 1'b0;
        check("gap_cleared", int'(time_late), 0);
        start = 1'b1; step(); start = 1'b0;
        repeat (3) step();
        clear_late = 1'b1; step(); clear_late = 1'b0;
        check("gap_set_wins", int'(time_late), 1);
        stop = 1'b1; step(); stop = 1'b0;
        check("stop_busy", int'(busy), 0);

        // Beat on the window-end tick is counted.
        window_with_end_beat();

        // Beat on the fourth gap tick suppresses the alarm.
        start = 1'b1; step(); start = 1'b0;
        repeat (3) step();
        beat = 1'b1; step(); beat = 1'b0;
        check("gapbeat_no_alarm", int'(time_late), 0);
        repeat (3) step();
        check("gapbeat_still_low", int'(time_late), 0);
        step();
        check("gapbeat_next_alarm", int'(time_late), 1);
        stop = 1'b1; step(); stop = 1'b0;

        // Stop on the window-end tick wins.
        start = 1'b1; step(); start = 1'b0;
        repeat (9) step();
        stop = 1'b1; step(); stop = 1'b0;
        check("stopend_valid", int'(bpm_valid), 0);
        check("stopend_bpm", int'(bpm), 6);
        check("stopend_busy", int'(busy), 0);
        step();

        // Continuous mode: 10 ticks + 1 report cycle per window, then exit.
        cont = 1'b1; start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            check($sformatf("cont_valid_c%0d", c), int'(bpm_valid), (c == 11 || c == 22 || c == 33) ? 1 : 0);
            check($sformatf("cont_busy_c%0d", c), int'(busy), (c <= 33) ? 1 : 0);
            if (c == 23) cont = 1'b0;
            step();
        end

        // Narrow instance: product and counter saturation.
        sat_run(8, 48);
        sat_run(11, 63);
        sat_run(100, 63);

        // Randomized traffic against the model.
        rst_n = 1'b0; #3;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 800; n++) begin
            tick = ($urandom_range(0, 9) < 7);
            start = ($urandom_range(0, 9) == 0);
            stop = ($urandom_range(0, 59) == 0);
            beat = ($urandom_range(0, 3) == 0);
            clear_late = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) cont = ~cont;
            model_step(int'(tick), int'(start), int'(stop), int'(cont), int'(beat), int'(clear_late));
            step();
            check($sformatf("rnd%0d_busy", n), int'(busy), m_busy);
            check($sformatf("rnd%0d_valid", n), int'(bpm_valid), m_valid);
            check($sformatf("rnd%0d_bpm", n), int'(bpm), m_bpm);
            check($sformatf("rnd%0d_late", n), int'(time_late), m_late);
        end
        tick = 1'b1; start = 1'b0; stop = 1'b1; beat = 1'b0; clear_late = 1'b0; cont = 1'b0;
        step(); stop = 1'b0; step();

        // Asynchronous reset mid-window.
        window_with_end_beat();
        start = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_late", int'(time_late), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_valid", int'(bpm_valid), 0);
        check("arst_bpm", int'(bpm), 0);
        check("arst_late", int'(time_late), 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("post_rst_idle", int'(busy), 0);
        start = 1'b1; step(); start = 1'b0;
        check("post_rst_start", int'(busy), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
